// File: rtl/lsu_pkg.sv
// Shared types for the memory-stage load/store unit.
// Size codes follow the RV32I funct3 load/store encodings.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_if.sv
// Word-addressed data bus between the LSU and memory.
// Request/grant for the address phase, rvalid for load data.
interface lsu_mem_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering, alignment check and load extension.
// Purely combinational; store side uses the live request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane,
  output logic        st_err,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // lane enables, replicated data and misalignment/illegal size
  always_comb begin
    st_be   = 4'b0000;
    st_lane = 32'h0;
    st_err  = 1'b0;
    unique case (1'b1)
      (st_size == SZ_B || st_size == SZ_BU): begin
        st_be   = 4'b0001 << st_off;
        st_lane = {4{st_wdata[7:0]}};
      end
      (st_size == SZ_H || st_size == SZ_HU): begin
        st_be   = 4'b0011 << st_off;
        st_lane = {2{st_wdata[15:0]}};
        st_err  = st_off[0];
      end
      (st_size == SZ_W): begin
        st_be   = 4'b1111;
        st_lane = st_wdata;
        st_err  = |st_off;
      end
      default: st_err = 1'b1;
    endcase
  end

  assign ld_byte = ld_rdata[8*ld_off +: 8];
  assign ld_half = ld_rdata[16*ld_off[1] +: 16];

  // pick the addressed byte/half and extend it
  always_comb begin
    ld_data = ld_rdata;
    unique case (1'b1)
      (ld_size == SZ_B):  ld_data = {{24{ld_byte[7]}}, ld_byte};
      (ld_size == SZ_BU): ld_data = {24'h0, ld_byte};
      (ld_size == SZ_H):  ld_data = {{16{ld_half[15]}}, ld_half};
      (ld_size == SZ_HU): ld_data = {16'h0, ld_half};
      default:            ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: one bus transaction per access.
// Holds the pipeline off via req_ready_o until the access retires.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [2:0]        mem_size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_addr_i,
  lsu_mem_if.master         bus,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              done_o,
  output logic              exc_o
);

  lsu_state_t state_q, state_d;

  logic        is_ld_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        go_req;
  logic        go_exc;
  logic        st_done;
  logic        ld_done;

  logic [3:0]  a_be;
  logic [31:0] a_lane;
  logic        a_err;
  logic [31:0] a_ld;

  lsu_align u_align (
    .st_size  (mem_size_i),
    .st_off   (addr_i[1:0]),
    .st_wdata (wdata_i),
    .st_be    (a_be),
    .st_lane  (a_lane),
    .st_err   (a_err),
    .ld_size  (size_q),
    .ld_off   (off_q),
    .ld_rdata (bus.rdata),
    .ld_data  (a_ld)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign accept = req_valid_i & req_ready_o
                & (mem_we_i | mem_re_i);

  // next state and one-cycle event strobes
  always_comb begin
    state_d = state_q;
    go_req  = 1'b0;
    go_exc  = 1'b0;
    st_done = 1'b0;
    ld_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (a_err) begin
            go_exc = 1'b1;
          end else begin
            go_req  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.gnt) begin
          if (is_ld_q) begin
            state_d = ST_RESP;
          end else begin
            st_done = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP: begin
        if (bus.rvalid) begin
          ld_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // registered bus outputs and latched access context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= 4'b0000;
      bus.wdata <= 32'h0;
      is_ld_q   <= 1'b0;
      size_q    <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
    end else if (go_req) begin
      bus.req   <= 1'b1;
      bus.we    <= mem_we_i;
      bus.addr  <= {addr_i[ADDR_W-1:2], 2'b00};
      bus.be    <= a_be;
      bus.wdata <= a_lane;
      is_ld_q   <= ~mem_we_i;
      size_q    <= mem_size_i;
      off_q     <= addr_i[1:0];
      rd_q      <= rd_addr_i;
    end else if (state_q == ST_REQ && bus.gnt) begin
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
    end
  end

  // completion, exception and writeback pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o       <= 1'b0;
      exc_o        <= 1'b0;
      wb_valid_o   <= 1'b0;
      wb_rd_addr_o <= 5'd0;
      wb_data_o    <= 32'h0;
    end else begin
      done_o     <= st_done | ld_done | go_exc;
      exc_o      <= go_exc;
      wb_valid_o <= ld_done;
      if (ld_done) begin
        wb_rd_addr_o <= rd_q;
        wb_data_o    <= a_ld;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Randomised and directed bench for lsu_mem.
// Expected values come from a byte-level model of the access rules.
module tb_lsu_mem;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  mem_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_addr;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        exc;

  int checks = 0;
  int errors = 0;
  int exp_bus = 0;
  int gnt_cnt = 0;

  lsu_mem_if #(.ADDR_W(32)) bus ();

  lsu_mem #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .mem_we_i     (mem_we),
    .mem_re_i     (mem_re),
    .mem_size_i   (mem_size),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rd_addr_i    (rd_addr),
    .bus          (bus.master),
    .wb_valid_o   (wb_valid),
    .wb_rd_addr_o (wb_rd_addr),
    .wb_data_o    (wb_data),
    .done_o       (done),
    .exc_o        (exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.req && bus.gnt) gnt_cnt++;

  function automatic logic m_err(input int sz, input int off);
    if (sz == 3 || sz == 6 || sz == 7) return 1'b1;
    if ((sz == 1 || sz == 5) && (off % 2) != 0) return 1'b1;
    if (sz == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input int off);
    if (sz == 0 || sz == 4) return 4'(1 << off);
    if (sz == 1 || sz == 5) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input int sz, input logic [31:0] w);
    if (sz == 0 || sz == 4) return (w & 32'hFF) * 32'h01010101;
    if (sz == 1 || sz == 5) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input int sz, input int off,
                                       input logic [31:0] r);
    logic [31:0] v;
    if (sz == 0 || sz == 4) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (sz == 0 && v >= 32'h80) v = v + 32'hFFFFFF00;
      return v;
    end
    if (sz == 1 || sz == 5) begin
      v = (r >> (8 * off)) & 32'hFFFF;
      if (sz == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      return v;
    end
    return r;
  endfunction

  task automatic run_access(input logic t_we, input logic t_re,
                            input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [4:0] rd,
                            input int gd, input int rvd,
                            input logic [31:0] rdat);
    int off;
    logic err;
    logic [3:0] ebe;
    logic [31:0] ewd;
    logic [31:0] edat;
    off  = int'(a[1:0]);
    err  = m_err(int'(sz), off);
    ebe  = m_be(int'(sz), off);
    ewd  = m_wd(int'(sz), wd);
    edat = m_ld(int'(sz), off, rdat);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; mem_we = t_we; mem_re = t_re;
    mem_size = sz; addr = a; wdata = wd; rd_addr = rd;
    @(negedge clk);
    req_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    addr = $urandom; wdata = $urandom; mem_size = 3'($urandom);
    if (!t_we && !t_re) begin
      checks++;
      if ({done, exc, bus.req, req_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL noop got=%b exp=0001",
                 {done, exc, bus.req, req_ready});
      end
      return;
    end
    if (err) begin
      checks++;
      if ({exc, done, bus.req, wb_valid, req_ready} !== 5'b11001) begin
        errors++;
        $display("FAIL misalign sz=%0d a=%h got=%b exp=11001", sz, a,
                 {exc, done, bus.req, wb_valid, req_ready});
      end
      @(negedge clk);
      checks++;
      if ({exc, done, bus.req} !== 3'b000) begin
        errors++;
        $display("FAIL exc_pulse got=%b exp=000", {exc, done, bus.req});
      end
      return;
    end
    exp_bus++;
    checks++;
    if ({bus.req, bus.we, req_ready} !== {1'b1, t_we, 1'b0}) begin
      errors++;
      $display("FAIL req_start got=%b exp=%b",
               {bus.req, bus.we, req_ready}, {1'b1, t_we, 1'b0});
    end
    checks++;
    if (bus.addr !== (a & 32'hFFFFFFFC) || bus.be !== ebe) begin
      errors++;
      $display("FAIL addr_be got=%h/%b exp=%h/%b", bus.addr, bus.be,
               a & 32'hFFFFFFFC, ebe);
    end
    if (t_we) begin
      checks++;
      if (bus.wdata !== ewd) begin
        errors++;
        $display("FAIL wdata got=%h exp=%h", bus.wdata, ewd);
      end
    end
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.req, req_ready, bus.be, bus.addr} !==
          {1'b1, 1'b0, ebe, a & 32'hFFFFFFFC}) begin
        errors++;
        $display("FAIL gnt_stall cyc=%0d req=%b rdy=%b be=%b a=%h",
                 i, bus.req, req_ready, bus.be, bus.addr);
      end
    end
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    if (t_we) begin
      checks++;
      if ({done, exc, bus.req, wb_valid, req_ready} !== 5'b10001) begin
        errors++;
        $display("FAIL store_done got=%b exp=10001",
                 {done, exc, bus.req, wb_valid, req_ready});
      end
      return;
    end
    checks++;
    if ({bus.req, done, req_ready} !== 3'b000) begin
      errors++;
      $display("FAIL resp_enter got=%b exp=000",
               {bus.req, done, req_ready});
    end
    for (int i = 0; i < rvd; i++) begin
      bus.rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({wb_valid, req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL resp_stall got=%b exp=00", {wb_valid, req_ready});
      end
    end
    bus.rvalid = 1'b1; bus.rdata = rdat;
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rdata = $urandom;
    checks++;
    if ({wb_valid, done, exc, req_ready} !== 4'b1101) begin
      errors++;
      $display("FAIL load_done got=%b exp=1101",
               {wb_valid, done, exc, req_ready});
    end
    checks++;
    if (wb_data !== edat || wb_rd_addr !== rd) begin
      errors++;
      $display("FAIL load_data got=%h/%0d exp=%h/%0d",
               wb_data, wb_rd_addr, edat, rd);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, bus.req, bus.we, bus.be, bus.addr, bus.wdata,
         wb_valid, wb_rd_addr, wb_data, done, exc} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals rdy=%b req=%b be=%b wbv=%b done=%b exc=%b",
               req_ready, bus.req, bus.be, wb_valid, done, exc);
    end
  endtask

  task automatic test_directed;
    run_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h000000A5, 5'd0,
               0, 0, 32'h0);
    run_access(1'b0, 1'b1, 3'b000, 32'h2002, 32'h0, 5'd7,
               0, 0, 32'h12803456);
    run_access(1'b0, 1'b1, 3'b100, 32'h2002, 32'h0, 5'd8,
               0, 0, 32'h12803456);
    run_access(1'b0, 1'b1, 3'b101, 32'h2002, 32'h0, 5'd9,
               0, 0, 32'h12803456);
    run_access(1'b0, 1'b1, 3'b001, 32'h2001, 32'h0, 5'd1,
               0, 0, 32'h0);
    run_access(1'b1, 1'b0, 3'b010, 32'h2002, 32'h1234, 5'd0,
               0, 0, 32'h0);
    run_access(1'b0, 1'b1, 3'b011, 32'h2000, 32'h0, 5'd2,
               0, 0, 32'h0);
    run_access(1'b1, 1'b1, 3'b001, 32'h3002, 32'hCAFEBEEF, 5'd3,
               1, 0, 32'h0);
  endtask

  task automatic test_grant_delay;
    run_access(1'b0, 1'b1, 3'b010, 32'h4000, 32'h0, 5'd10,
               3, 0, 32'h89ABCDEF);
    run_access(1'b0, 1'b1, 3'b001, 32'h4006, 32'h0, 5'd11,
               2, 3, 32'h8001_7FFF);
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; mem_re = 1'b1; mem_size = 3'b010;
    addr = 32'h5000; rd_addr = 5'd4;
    @(negedge clk);
    req_valid = 1'b0; mem_re = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_req got=%b exp=0", bus.req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; mem_re = 1'b1; mem_size = 3'b010;
    addr = 32'h5004; rd_addr = 5'd5;
    @(negedge clk);
    req_valid = 1'b0; mem_re = 1'b0;
    bus.gnt = 1'b1;
    exp_bus++;
    @(negedge clk);
    bus.gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({wb_valid, done, bus.req, req_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL rst_resp cyc=%0d got=%b exp=0001", i,
                 {wb_valid, done, bus.req, req_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int g0;
    g0 = gnt_cnt;
    run_access(1'b1, 1'b0, 3'b010, 32'h6000, 32'h11223344, 5'd0,
               0, 0, 32'h0);
    checks++;
    if ({done, req_ready} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_done_ready got=%b exp=11", {done, req_ready});
    end
    run_access(1'b0, 1'b1, 3'b010, 32'h6000, 32'h0, 5'd12,
               0, 0, 32'h55667788);
    checks++;
    if (gnt_cnt - g0 !== 2) begin
      errors++;
      $display("FAIL b2b_grants got=%0d exp=2", gnt_cnt - g0);
    end
  endtask

  task automatic test_random;
    logic t_we, t_re;
    logic [2:0] sz;
    for (int n = 0; n < 80; n++) begin
      t_we = 1'($urandom);
      t_re = t_we ? 1'($urandom) : 1'b1;
      if ($urandom_range(7) == 0) begin
        t_we = 1'b0; t_re = 1'b0;
      end
      sz = 3'($urandom);
      if (t_we && (sz == 3'd4 || sz == 3'd5)) sz = sz - 3'd4;
      run_access(t_we, t_re, sz, $urandom, $urandom, 5'($urandom),
                 $urandom_range(3), $urandom_range(3), $urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    mem_size = 3'b000; addr = 32'h0; wdata = 32'h0; rd_addr = 5'd0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_directed;
    test_grant_delay;
    test_reset_mid;
    test_back_to_back;
    test_random;
    @(negedge clk);
    checks++;
    if (gnt_cnt !== exp_bus) begin
      errors++;
      $display("FAIL grant_count got=%0d exp=%0d", gnt_cnt, exp_bus);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Memory-stage load/store unit for the RV32I pipeline. It accepts one access per transaction from the EX/MEM register: the store/load enables, the funct3 size code and the store data produced by decode, plus the effective address from EX. It drives a word-addressed data bus with a request/grant/response handshake and returns sign- or zero-extended load data for writeback. It back-pressures the pipeline through a ready signal until the bus transaction completes.

## Interface
- `ADDR_W`, default 32: bus and effective-address width.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: an access is present on the request inputs.
- `req_ready_o` out 1: unit can accept; a transfer occurs when valid and ready are both high.
- `mem_we_i` in 1: store.
- `mem_re_i` in 1: load.
- `mem_size_i` in 3: funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr_i` in ADDR_W: effective byte address.
- `wdata_i` in 32: store data, right-aligned in the low bits.
- `rd_addr_i` in 5: load destination register.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: bus write.
- `bus_addr_o` out ADDR_W: word-aligned address, with [1:0] forced to 00.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_gnt_i` in 1: bus accepted the request this cycle.
- `bus_rvalid_i` in 1: load data valid.
- `bus_rdata_i` in 32: load data.
- `wb_valid_o` out 1: one-cycle pulse carrying load writeback.
- `wb_rd_addr_o` out 5: writeback register.
- `wb_data_o` out 32: extended load data.
- `done_o` out 1: one-cycle pulse when any access completes, including an error.
- `exc_o` out 1: one-cycle pulse for a misaligned access or an illegal size.

## Operation
- **States:** IDLE, REQ, RESP.
  - `req_ready_o` is 1 only in IDLE.
- **Accept.** A transfer in IDLE with `mem_we_i` or `mem_re_i` set latches the operation, size, address, byte enables, lane data and rd. The FSM then moves to REQ.
  - `mem_we_i` takes precedence if both enables are set.
  - A transfer with neither enable set is ignored.
- **REQ.**
  - `bus_req_o`=1, and all bus outputs are held stable.
  - On `bus_gnt_i`: a store goes to IDLE and pulses `done_o`; a load goes to RESP.
- **RESP.**
  - `bus_req_o`=0.
  - On `bus_rvalid_i`: the FSM goes to IDLE and, on the next cycle, pulses `wb_valid_o` and `done_o` with the extracted data.
  - `bus_rvalid_i` is ignored in IDLE and REQ.
- **Error.** The access is an error if:
  - the size is H/HU with `addr[0]`=1, or
  - the size is W with `addr[1:0]`≠00, or
  - the size code is 011, 110 or 111.

  On an error there is no bus activity, the FSM stays in IDLE, and `exc_o` and `done_o` pulse the next cycle. `wb_valid_o` stays 0.
- **Byte lanes, with off = `addr[1:0]`.**
  - B: `be` = 0001<<off, `wdata` = {4{wdata_i[7:0]}}.
  - H: `be` = 0011<<off, `wdata` = {2{wdata_i[15:0]}}.
  - W: `be` = 1111, `wdata` = `wdata_i`.
- **Load extract.**
  - byte = `rdata[8*off +: 8]`; half = `rdata[16*off[1] +: 16]`.
  - B and H sign-extend; BU and HU zero-extend; W passes through.

## Timing
- **Reset values.** All outputs are 0 except `req_ready_o`=1; the FSM is in IDLE.
- **Reset mid-transaction.**
  - Asserting `rst_n` low drops `bus_req_o` immediately (asynchronous).
  - A later `bus_rvalid_i` for the aborted load is ignored.
- **Minimum latency.**
  - Store: accept at T0, `bus_req_o` at T1 with grant, `done_o` at T2.
  - Load: accept at T0, grant at T1, rvalid at T2, `wb_valid_o` at T3.
- **Stalls.** A grant or response delayed N cycles extends REQ or RESP by N cycles.
- **Back-to-back.** A new access can be accepted in the same cycle `done_o` is high, because the FSM is already in IDLE.
- **Registered outputs.** All bus outputs are registered. `req_ready_o` is decoded from the state only.

## Structure
- `lsu_pkg` holds:
  - size localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), matching the funct3 load/store encodings;
  - the state enum `lsu_state_t`.
- Sub-module `lsu_align` (combinational) holds:
  - the byte-enable and write-data lane steering;
  - the load byte/half extraction and extension;
  - the misalignment check.
- The FSM and registers live in `lsu_mem`.

## Test plan
- **Byte store.** SB, `addr`=0x1003, `wdata`=0x000000A5, grant on first cycle -> `bus_addr`=0x1000, `be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_we`=1, `done_o` at T2.
- **Byte loads.** LB, `addr`=0x2002, `rdata`=0x12803456 -> `wb_data`=0xFFFFFF80, `wb_valid` at T3. Repeat as LBU -> 0x00000080. LHU at offset 2 -> 0x00001280.
- **Misalignment.** LH at 0x2001 -> `exc_o` and `done_o` pulse the next cycle, `bus_req_o` never high, `wb_valid_o`=0. Same for SW at 0x2002 and for size 011.
- **Grant delay.** LW with `bus_gnt_i` held low for 3 cycles -> `bus_req_o`, `bus_addr_o` and `bus_be_o` stable, `req_ready_o`=0 throughout; the result follows 1 cycle after rvalid.
- **Reset during RESP.** Pull `rst_n` low while in RESP, then release; assert `bus_rvalid_i` with 0xDEADBEEF -> no `wb_valid_o`, FSM in IDLE, `req_ready_o`=1.
- **Back-to-back.** SW then LW back-to-back -> the second access is accepted in the `done_o` cycle of the first, and no request is dropped or duplicated.
